pipeline_sequencer: RTL and testbench

- Parametrised pipeline-motion controller and latch chain that replaces the hand-wired per-latch WEN/flush registers in the datapath.
- Carries a WIDTH-bit payload plus a valid bit and a halt bit through STAGES latches.
- Resolves per-stage stall requests into upstream backpressure that collapses bubbles, and applies per-stage flushes.
- Freezes fetch when a halt is in flight, and counts retired instructions and stall cycles.

---
 rtl/pipeline_sequencer.sv | 123 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Pipeline latch chain with stall/backpressure resolution, per-stage flush,
// halt-driven fetch freeze and retire/stall performance counters.
module pipeline_sequencer #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 64,
  parameter int CNT_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_halt,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stage_stall,
  input  logic [STAGES-1:0]         flush_mask,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [STAGES-1:0]         stage_advance,
  output logic                      retire_valid,
  output logic [WIDTH-1:0]          retire_data,
  output logic                      halted,
  output logic [CNT_W-1:0]          retire_count,
  output logic [CNT_W-1:0]          stall_count
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_halt;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic              r_halted;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [STAGES-1:0] w_live;
  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_pass;
  logic              w_inflight;
  logic              w_fire;
  logic              w_retire;

  assign w_live     = r_valid & ~flush_mask;
  assign w_pass     = w_live & ~w_hold;
  assign w_inflight = |(w_live & r_halt);
  assign w_retire   = w_live[STAGES-1] & ~stage_stall[STAGES-1];
  assign w_fire     = in_valid & in_ready;

  // A stall only propagates upstream through occupied stages, so bubbles collapse.
  always_comb begin
    w_hold = '0;
    w_hold[STAGES-1] = w_live[STAGES-1] & stage_stall[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) begin
      w_hold[i] = w_live[i] & (stage_stall[i] | w_hold[i+1]);
    end
  end

  assign in_ready      = ~w_hold[0] & ~w_inflight & ~r_halted & ~RST;
  assign stage_advance = ~w_hold;
  assign stage_valid   = r_valid;
  assign retire_valid  = w_retire;
  assign retire_data   = r_data[STAGES-1];
  assign halted        = r_halted;
  assign retire_count  = r_retire_cnt;
  assign stall_count   = r_stall_cnt;

  genvar g;
  for (g = 0; g < STAGES; g++) begin : g_data
    assign stage_data[g*WIDTH +: WIDTH] = r_data[g];
  end

  // Latch chain; a bubble clears valid but leaves the payload untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= '0;
      r_halt  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      if (!w_hold[0]) begin
        r_valid[0] <= w_fire;
        r_halt[0]  <= w_fire & in_halt;
        if (w_fire) begin
          r_data[0] <= in_data;
        end
      end else begin
        r_valid[0] <= r_valid[0] & ~flush_mask[0];
      end
      for (int i = 1; i < STAGES; i++) begin
        if (!w_hold[i]) begin
          if (w_pass[i-1]) begin
            r_valid[i] <= 1'b1;
            r_halt[i]  <= r_halt[i-1];
            r_data[i]  <= r_data[i-1];
          end else begin
            r_valid[i] <= 1'b0;
            r_halt[i]  <= 1'b0;
          end
        end else begin
          r_valid[i] <= r_valid[i] & ~flush_mask[i];
        end
      end
    end
  end

  // Sticky halt flag and free-running performance counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_halted     <= 1'b0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_retire && r_halt[STAGES-1]) begin
        r_halted <= 1'b1;
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      if (in_valid && !in_ready) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (STAGES=4, WIDTH=8).
module tb_pipeline_sequencer;
  localparam int S = 4;
  localparam int W = 8;
  localparam int C = 32;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_halt = 1'b0;
  logic           in_ready;
  logic [S-1:0]   stage_stall = '0;
  logic [S-1:0]   flush_mask = '0;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic [S-1:0]   stage_advance;
  logic           retire_valid;
  logic [W-1:0]   retire_data;
  logic           halted;
  logic [C-1:0]   retire_count;
  logic [C-1:0]   stall_count;

  int checks = 0;
  int errors = 0;

  pipeline_sequencer #(.STAGES(S), .WIDTH(W), .CNT_W(C)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_halt(in_halt),
    .in_ready(in_ready), .stage_stall(stage_stall), .flush_mask(flush_mask),
    .stage_valid(stage_valid), .stage_data(stage_data), .stage_advance(stage_advance),
    .retire_valid(retire_valid), .retire_data(retire_data), .halted(halted),
    .retire_count(retire_count), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic feed(input logic v, input logic [W-1:0] d, input logic h);
    in_valid = v;
    in_data  = d;
    in_halt  = h;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    feed(1'b0, 8'h00, 1'b0);
    stage_stall = '0;
    flush_mask  = '0;
    nxt();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    feed(1'b1, 8'hEE, 1'b0);
    mid();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", stage_valid); end
    checks++; if (stage_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", stage_data); end
    checks++; if (halted !== 1'b0 || retire_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_state got halted=%b ret=%0d stall=%0d exp 0/0/0", halted, retire_count, stall_count);
    end
    nxt();
    do_reset();
  endtask

  task automatic test_streaming();
    logic [W-1:0] d [5];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c < 5) feed(1'b1, d[c], 1'b0); else feed(1'b0, 8'h00, 1'b0);
      mid();
      if (c < 5) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d got %b exp 1", c, in_ready); end
      end
      if (c >= 4) begin
        checks++;
        if (retire_valid !== 1'b1 || retire_data !== d[c-4]) begin
          errors++; $display("FAIL stream_retire c%0d got v=%b d=%h exp v=1 d=%h", c, retire_valid, retire_data, d[c-4]);
        end
      end else begin
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL stream_early c%0d got %b exp 0", c, retire_valid); end
      end
      nxt();
    end
    mid();
    checks++; if (retire_count !== 32'd5 || stall_count !== 32'd0) begin
      errors++; $display("FAIL stream_counts got ret=%0d stall=%0d exp 5/0", retire_count, stall_count);
    end
    nxt();
  endtask

  task automatic test_bubble_collapse();
    logic [W-1:0] r [4];
    r[0] = 8'h22; r[1] = 8'h11; r[2] = 8'h33; r[3] = 8'h44;
    do_reset();
    feed(1'b1, 8'h22, 1'b0); nxt();
    feed(1'b0, 8'h00, 1'b0); nxt(); nxt();
    feed(1'b1, 8'h11, 1'b0); nxt();
    stage_stall = 4'b1000;
    feed(1'b1, 8'h33, 1'b0);
    mid();
    checks++; if (stage_valid !== 4'b1001 || in_ready !== 1'b1 || retire_valid !== 1'b0) begin
      errors++; $display("FAIL bubble_c4 got valid=%b rdy=%b ret=%b exp 1001/1/0", stage_valid, in_ready, retire_valid);
    end
    nxt();
    feed(1'b1, 8'h44, 1'b0);
    mid();
    checks++; if (stage_valid !== 4'b1011 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bubble_c5 got valid=%b rdy=%b exp 1011/1", stage_valid, in_ready);
    end
    nxt();
    feed(1'b1, 8'h55, 1'b0);
    mid();
    checks++; if (stage_valid !== 4'b1111 || stage_data !== 32'h22113344) begin
      errors++; $display("FAIL bubble_full got valid=%b data=%h exp 1111/22113344", stage_valid, stage_data);
    end
    checks++; if (in_ready !== 1'b0 || stage_advance !== 4'b0000) begin
      errors++; $display("FAIL bubble_bp got rdy=%b adv=%b exp 0/0000", in_ready, stage_advance);
    end
    nxt();
    stage_stall = 4'b0000;
    feed(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++; if (retire_valid !== 1'b1 || retire_data !== r[c]) begin
        errors++; $display("FAIL bubble_retire %0d got v=%b d=%h exp v=1 d=%h", c, retire_valid, retire_data, r[c]);
      end
      nxt();
    end
    mid();
    checks++; if (retire_count !== 32'd4 || stall_count !== 32'd1) begin
      errors++; $display("FAIL bubble_counts got ret=%0d stall=%0d exp 4/1", retire_count, stall_count);
    end
    nxt();
  endtask

  task automatic test_stall_empty();
    do_reset();
    stage_stall = 4'b0100;
    feed(1'b1, 8'h5A, 1'b0);
    mid();
    checks++; if (stage_advance !== 4'b1111 || in_ready !== 1'b1) begin
      errors++; $display("FAIL empty_stall got adv=%b rdy=%b exp 1111/1", stage_advance, in_ready);
    end
    nxt();
    feed(1'b0, 8'h00, 1'b0);
    mid();
    checks++; if (stage_advance !== 4'b1111 || stage_valid !== 4'b0001) begin
      errors++; $display("FAIL empty_stall2 got adv=%b valid=%b exp 1111/0001", stage_advance, stage_valid);
    end
    nxt(); nxt();
    mid();
    checks++; if (stage_advance !== 4'b1011 || stage_valid !== 4'b0100) begin
      errors++; $display("FAIL occupied_stall got adv=%b valid=%b exp 1011/0100", stage_advance, stage_valid);
    end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL empty_stall_cnt got %0d exp 0", stall_count); end
    nxt();
    stage_stall = 4'b0000;
  endtask

  task automatic test_flush_stall();
    do_reset();
    feed(1'b1, 8'hA3, 1'b0); nxt();
    feed(1'b1, 8'hA2, 1'b0); nxt();
    feed(1'b1, 8'hA1, 1'b0); nxt();
    feed(1'b1, 8'hA0, 1'b0); nxt();
    flush_mask  = 4'b0011;
    stage_stall = 4'b0010;
    feed(1'b1, 8'hB0, 1'b0);
    mid();
    checks++; if (stage_data !== 32'hA3A2A1A0 || stage_valid !== 4'b1111) begin
      errors++; $display("FAIL flush_pre got data=%h valid=%b exp A3A2A1A0/1111", stage_data, stage_valid);
    end
    checks++; if (in_ready !== 1'b1 || stage_advance !== 4'b1111 || retire_data !== 8'hA3 || retire_valid !== 1'b1) begin
      errors++; $display("FAIL flush_cycle got rdy=%b adv=%b ret=%b/%h exp 1/1111/1/a3", in_ready, stage_advance, retire_valid, retire_data);
    end
    nxt();
    flush_mask  = 4'b0000;
    stage_stall = 4'b0000;
    feed(1'b0, 8'h00, 1'b0);
    mid();
    checks++; if (stage_valid !== 4'b1001 || retire_data !== 8'hA2 || retire_valid !== 1'b1) begin
      errors++; $display("FAIL flush_after got valid=%b ret=%b/%h exp 1001/1/a2", stage_valid, retire_valid, retire_data);
    end
    nxt();
    for (int c = 0; c < 2; c++) begin
      mid();
      checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL flush_killed %0d got %b exp 0", c, retire_valid); end
      nxt();
    end
    mid();
    checks++; if (retire_valid !== 1'b1 || retire_data !== 8'hB0) begin
      errors++; $display("FAIL flush_b0 got v=%b d=%h exp 1/b0", retire_valid, retire_data);
    end
    nxt();
    mid();
    checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL flush_count got %0d exp 3", retire_count); end
    nxt();
  endtask

  task automatic test_halt_flush();
    do_reset();
    feed(1'b1, 8'h01, 1'b0); nxt();
    feed(1'b1, 8'h02, 1'b1); nxt();
    feed(1'b0, 8'h00, 1'b0);
    mid();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hflush_block got %b exp 0", in_ready); end
    nxt();
    flush_mask = 4'b0010;
    feed(1'b1, 8'h03, 1'b0);
    mid();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hflush_resume got %b exp 1", in_ready); end
    nxt();
    flush_mask = 4'b0000;
    feed(1'b0, 8'h00, 1'b0);
    nxt(); nxt(); nxt();
    mid();
    checks++; if (retire_valid !== 1'b1 || retire_data !== 8'h03) begin
      errors++; $display("FAIL hflush_retire got v=%b d=%h exp 1/03", retire_valid, retire_data);
    end
    nxt();
    mid();
    checks++; if (halted !== 1'b0 || retire_count !== 32'd2 || stall_count !== 32'd0) begin
      errors++; $display("FAIL hflush_end got halted=%b ret=%0d stall=%0d exp 0/2/0", halted, retire_count, stall_count);
    end
    nxt();
  endtask

  task automatic test_halt();
    do_reset();
    feed(1'b1, 8'h01, 1'b0);
    mid();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL halt_r0 got %b exp 1", in_ready); end
    nxt();
    feed(1'b1, 8'h02, 1'b1);
    mid();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL halt_r1 got %b exp 1", in_ready); end
    nxt();
    feed(1'b0, 8'h00, 1'b0);
    for (int c = 2; c < 6; c++) begin
      mid();
      checks++; if (in_ready !== 1'b0 || halted !== 1'b0) begin
        errors++; $display("FAIL halt_wait c%0d got rdy=%b halted=%b exp 0/0", c, in_ready, halted);
      end
      if (c == 5) begin
        checks++; if (retire_valid !== 1'b1 || retire_data !== 8'h02) begin
          errors++; $display("FAIL halt_retire got v=%b d=%h exp 1/02", retire_valid, retire_data);
        end
      end
      nxt();
    end
    feed(1'b1, 8'h09, 1'b0);
    mid();
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL halt_set got halted=%b rdy=%b exp 1/0", halted, in_ready);
    end
    nxt(); nxt();
    feed(1'b0, 8'h00, 1'b0);
    mid();
    checks++; if (halted !== 1'b1 || stall_count !== 32'd2 || retire_count !== 32'd2) begin
      errors++; $display("FAIL halt_end got halted=%b stall=%0d ret=%0d exp 1/2/2", halted, stall_count, retire_count);
    end
    nxt();
  endtask

  task automatic test_async_reset();
    RST = 1'b1;
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b exp 0", in_ready); end
    #2;
    RST = 1'b0;
    #2;
    checks++; if (halted !== 1'b0 || retire_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL async_clear1 got halted=%b ret=%0d stall=%0d exp 0/0/0", halted, retire_count, stall_count);
    end
    nxt();
    for (int c = 0; c < 6; c++) begin
      feed(1'b1, 8'h70 + 8'(c), 1'b0);
      nxt();
    end
    feed(1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (retire_count !== 32'd2 || stage_valid !== 4'b1111) begin
      errors++; $display("FAIL async_pre got ret=%0d valid=%b exp 2/1111", retire_count, stage_valid);
    end
    RST = 1'b1;
    #5;
    RST = 1'b0;
    #2;
    checks++; if (stage_valid !== 4'b0000 || stage_data !== 32'h0 || retire_count !== 32'd0 || retire_valid !== 1'b0) begin
      errors++; $display("FAIL async_clear2 got valid=%b data=%h ret=%0d rv=%b exp 0/0/0/0", stage_valid, stage_data, retire_count, retire_valid);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_bubble_collapse();
    test_stall_empty();
    test_flush_stall();
    test_halt_flush();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
